// File: rtl/izigzag_buffer_if.sv
// rtl/izigzag_buffer_if.sv - coefficient stream bundle for the inverse zigzag buffer
//
// Groups the input stream (din/din_valid/din_ready) and the output stream
// (dout/dout_valid/dout_ready/dout_last) of izigzag_buffer.
//   master : the side that drives din/din_valid/dout_ready (producer + consumer)
//   slave  : the buffer itself
interface izigzag_buffer_if #(
  parameter int DW = 12
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/izigzag_buffer.sv
// rtl/izigzag_buffer.sv - ping-pong buffer reordering JPEG zigzag coefficients to raster order
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : izigzag_buffer_if slave
//          din/din_valid/din_ready       - coefficients in zigzag order
//          dout/dout_valid/dout_ready    - coefficients in raster order (registered)
//          dout_last                     - marks raster position 63
module izigzag_buffer #(
  parameter int DW = 12
) (
  input  logic             clk,
  input  logic             rst,
  izigzag_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Zigzag index -> raster address.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DW-1:0] mem [2][64];

  bank_state_t bank_state     [2];
  bank_state_t bank_state_nxt [2];

  logic       wr_bank;
  logic       rd_bank;
  logic [5:0] wr_cnt;
  logic [5:0] rd_cnt;
  logic       wr_en;
  logic       rd_en;
  logic       rd_avail;

  // Depends only on registered bank state, never on dout_ready.
  assign bus.din_ready = (bank_state[wr_bank] == EMPTY) ||
                         (bank_state[wr_bank] == FILLING);

  always_comb begin
    bank_state_nxt[0] = bank_state[0];
    bank_state_nxt[1] = bank_state[1];
    wr_en    = bus.din_valid && bus.din_ready;
    rd_avail = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == DRAINING);
    // Load the output register whenever it is empty or being consumed.
    rd_en    = rd_avail && (!bus.dout_valid || bus.dout_ready);

    // A write needs EMPTY/FILLING and a read needs FULL/DRAINING, so the two
    // updates below never target the same bank in one cycle.
    if (wr_en) begin
      bank_state_nxt[wr_bank] = (wr_cnt == 6'd63) ? FULL : FILLING;
    end
    if (rd_en) begin
      bank_state_nxt[rd_bank] = (rd_cnt == 6'd63) ? EMPTY : DRAINING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
    end else begin
      bank_state[0] <= bank_state_nxt[0];
      bank_state[1] <= bank_state_nxt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 6'd0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + 6'd1;
      if (wr_cnt == 6'd63) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank RAM is not reset; a discarded partial block is simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][ZZ[wr_cnt]] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank        <= 1'b0;
      rd_cnt         <= 6'd0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
    end else if (rd_en) begin
      bus.dout       <= mem[rd_bank][rd_cnt];
      bus.dout_valid <= 1'b1;
      bus.dout_last  <= (rd_cnt == 6'd63);
      rd_cnt         <= rd_cnt + 6'd1;
      if (rd_cnt == 6'd63) begin
        rd_bank <= ~rd_bank;
      end
    end else if (bus.dout_ready) begin
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
    end
  end

endmodule
